// File: rtl/br_update_queue.sv
// In-order branch update queue feeding the TAGE commit-side update port.
// Optional statistics counters are built when BRQ_STATS_EN is defined.
module br_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic [1:0]       alloc_pred,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [IDX_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic             flush_valid,
    input  logic [IDX_W-1:0] flush_tag,
    output logic             update_valid,
    output logic [31:0]      update_pc,
    output logic             update_taken,
    output logic [1:0]       update_pred,
    output logic             update_mispredict,
    output logic [IDX_W:0]   count,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispred
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_resolved;
    logic [DEPTH-1:0] ent_taken;
    logic [31:0]      ent_pc   [DEPTH];
    logic [1:0]       ent_pred [DEPTH];

    logic [IDX_W:0]   head, tail;
    logic [IDX_W:0]   head_next, tail_next, count_next;
    logic [IDX_W-1:0] head_idx, tail_idx, flush_dist, res_dist;
    logic             flush_hit, flush_empty;
    logic             do_retire, do_alloc, do_resolve;
    logic [DEPTH-1:0] kill;

    // Handshake: an alloc transfers on a clock edge where alloc_valid && alloc_ready
    // and no flush is presented; alloc_ready depends on registered state only.
    assign alloc_ready = (count != FULL);
    assign alloc_tag   = tail[IDX_W-1:0];

    always_comb begin
        head_idx    = head[IDX_W-1:0];
        tail_idx    = tail[IDX_W-1:0];
        flush_dist  = flush_tag - head_idx;
        // A flush is only honoured when its tag lies inside the occupied window.
        flush_hit   = flush_valid && ({1'b0, flush_dist} < count);
        flush_empty = flush_hit && (flush_dist == '0);
        do_retire   = ent_valid[head_idx] && ent_resolved[head_idx] && !flush_empty;
        do_alloc    = alloc_valid && alloc_ready && !flush_valid;
        res_dist    = resolve_tag - head_idx;
        do_resolve  = resolve_valid && ent_valid[resolve_tag]
                      && !(flush_hit && (res_dist >= flush_dist));
        head_next   = head + {{IDX_W{1'b0}}, do_retire};
        if (flush_hit) begin
            // Tail lands at the same distance from head, so the wrap bit follows.
            tail_next  = head + {1'b0, flush_dist};
            count_next = tail_next - head_next;
        end else begin
            tail_next  = tail + {{IDX_W{1'b0}}, do_alloc};
            count_next = count + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, do_retire};
        end
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = flush_hit && (IDX_W'(IDX_W'(i) - head_idx) >= flush_dist);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            ent_valid         <= '0;
            ent_resolved      <= '0;
            ent_taken         <= '0;
            update_valid      <= 1'b0;
            update_pc         <= '0;
            update_taken      <= 1'b0;
            update_pred       <= 2'b00;
            update_mispredict <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_pred[i] <= '0;
            end
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) ent_valid[i] <= 1'b0;
            end
            if (do_retire) ent_valid[head_idx] <= 1'b0;
            if (do_resolve) begin
                ent_resolved[resolve_tag] <= 1'b1;
                ent_taken[resolve_tag]    <= resolve_taken;
            end
            if (do_alloc) begin
                ent_valid[tail_idx]    <= 1'b1;
                ent_resolved[tail_idx] <= 1'b0;
                ent_pc[tail_idx]       <= alloc_pc;
                ent_pred[tail_idx]     <= alloc_pred;
            end
            update_valid <= do_retire;
            if (do_retire) begin
                update_pc         <= ent_pc[head_idx];
                update_taken      <= ent_taken[head_idx];
                update_pred       <= ent_pred[head_idx];
                update_mispredict <= ent_pred[head_idx][1] != ent_taken[head_idx];
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (do_retire) begin
            if (stat_updates != 32'hFFFF_FFFF) stat_updates <= stat_updates + 32'd1;
            if ((ent_pred[head_idx][1] != ent_taken[head_idx]) && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`else
    assign stat_updates = '0;
    assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_br_update_queue.sv
// Self-checking bench for br_update_queue: directed scenarios plus random traffic
// compared every cycle against a tag-searching list model of the queue.
module tb_br_update_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [31:0]      alloc_pc = '0;
    logic [1:0]       alloc_pred = '0;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_tag;
    logic             resolve_valid = 1'b0;
    logic [IDX_W-1:0] resolve_tag = '0;
    logic             resolve_taken = 1'b0;
    logic             flush_valid = 1'b0;
    logic [IDX_W-1:0] flush_tag = '0;
    logic             update_valid;
    logic [31:0]      update_pc;
    logic             update_taken;
    logic [1:0]       update_pred;
    logic             update_mispredict;
    logic [IDX_W:0]   count;
    logic [31:0]      stat_updates;
    logic [31:0]      stat_mispred;

    br_update_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_pred(update_pred), .update_mispredict(update_mispredict),
        .count(count), .stat_updates(stat_updates), .stat_mispred(stat_mispred)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: age-ordered list of in-flight branches
    typedef struct {
        int       tag;
        bit [31:0] pc;
        bit [1:0] pred;
        bit       resolved;
        bit       taken;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    bit          exp_uv, exp_taken, exp_mis;
    bit [31:0]   exp_pc;
    bit [1:0]    exp_pred;
    longint      m_upd, m_mis;
    bit          m_alloc_fired;
    logic [34:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_tail = 0;
        exp_uv = 0; exp_taken = 0; exp_mis = 0; exp_pc = '0; exp_pred = '0;
        m_upd = 0; m_mis = 0;
    endtask

    // advances the model by one clock edge using the inputs currently applied
    task automatic model_step();
        int   sz = mq.size();
        bit   ret = (sz > 0) && mq[0].resolved;
        bit   acc = alloc_valid && (sz < DEPTH) && !flush_valid;
        ent_t e;
        if (flush_valid) begin
            int p = -1;
            for (int i = 0; i < sz; i++) if (mq[i].tag == int'(flush_tag)) p = i;
            if (p == 0) ret = 0;
            if (p >= 0) begin
                while (mq.size() > p) void'(mq.pop_back());
                m_tail = int'(flush_tag);
            end
        end
        exp_uv = ret;
        if (ret) begin
            e = mq.pop_front();
            exp_pc = e.pc; exp_pred = e.pred; exp_taken = e.taken;
            exp_mis = (e.pred[1] != e.taken);
            exp_q.push_back({e.pc, e.pred, e.taken});
            if (m_upd < 64'hFFFF_FFFF) m_upd++;
            if (exp_mis && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
        if (resolve_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == int'(resolve_tag)) begin
                    mq[i].resolved = 1;
                    mq[i].taken    = resolve_taken;
                end
            end
        end
        m_alloc_fired = acc;
        if (acc) begin
            e.tag = m_tail; e.pc = alloc_pc; e.pred = alloc_pred; e.resolved = 0; e.taken = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic check_all();
        logic [34:0] s;
        check("count", count, mq.size());
        check("alloc_ready", alloc_ready, mq.size() < DEPTH);
        check("alloc_tag", alloc_tag, m_tail);
        check("update_valid", update_valid, exp_uv);
        check("update_pc", update_pc, exp_pc);
        check("update_pred", update_pred, exp_pred);
        check("update_taken", update_taken, exp_taken);
        check("update_mispredict", update_mispredict, exp_mis);
`ifdef BRQ_STATS_EN
        check("stat_updates", stat_updates, m_upd);
        check("stat_mispred", stat_mispred, m_mis);
`else
        check("stat_updates", stat_updates, 0);
        check("stat_mispred", stat_mispred, 0);
`endif
        if (update_valid === 1'b1) begin
            if (exp_q.size() == 0) check("sb_underflow", update_valid, 0);
            else begin
                s = exp_q.pop_front();
                check("sb_pulse", {update_pc, update_pred, update_taken}, s);
            end
        end
    endtask

    // driver tasks: inputs are changed 1 time unit after a rising edge
    task automatic set_in(input bit av, input logic [31:0] pc, input logic [1:0] pr,
                          input bit rv, input int rt, input bit rk,
                          input bit fv, input int ft);
        alloc_valid = av; alloc_pc = pc; alloc_pred = pr;
        resolve_valid = rv; resolve_tag = IDX_W'(rt); resolve_taken = rk;
        flush_valid = fv; flush_tag = IDX_W'(ft);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic alloc_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set_in(1, base + 32'(i * 4), 2'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        int allocs;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        check("reset_alloc_ready", alloc_ready, 1);
        check("reset_alloc_tag", alloc_tag, 0);
        rst = 1;

        // single branch
        set_in(1, 32'h100, 2'b10, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0, 0, 0); step();
        check("single_count_before", count, 1);
        idle(1);
        check("single_pulse", update_valid, 1);
        check("single_pc", update_pc, 32'h100);
        check("single_mispredict", update_mispredict, 1);
        check("single_count_after", count, 0);
        idle(2);

        // out-of-order resolve
        do_reset();
        alloc_n(3, 32'h2000);
        set_in(0, 0, 0, 1, 2, 1, 0, 0); step();
        set_in(0, 0, 0, 1, 1, 0, 0, 0); step();
        idle(1);
        check("ooo_no_pulse", update_valid, 0);
        set_in(0, 0, 0, 1, 0, 1, 0, 0); step();
        idle(4);

        // full and wrap, 20 allocations
        do_reset();
        alloc_n(8, 32'h3000);
        check("full_ready", alloc_ready, 0);
        check("full_count", count, 8);
        allocs = 8;
        for (int c = 0; c < 200 && (allocs < 20 || mq.size() > 0); c++) begin
            set_in(allocs < 20, 32'h3100 + 32'(allocs * 4), 2'($urandom_range(0, 3)),
                   mq.size() > 0, (mq.size() > 0) ? mq[0].tag : 0, 1'($urandom_range(0, 1)), 0, 0);
            step();
            if (m_alloc_fired) allocs++;
        end
        check("wrap_allocs", allocs, 20);
        check("wrap_drained", count, 0);

        // flush
        do_reset();
        alloc_n(5, 32'h4000);
        set_in(0, 0, 0, 1, 3, 1, 1, 2); step();
        check("flush_count", count, 2);
        check("flush_tag_next", alloc_tag, 2);
        set_in(0, 0, 0, 1, 3, 1, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0); step();
        check("flush_head_count", count, 0);
        check("flush_head_no_pulse", update_valid, 0);
        idle(3);

        // asynchronous reset mid-stream
        do_reset();
        alloc_n(6, 32'h5000);
        set_in(0, 0, 0, 1, 0, 0, 0, 0); step();
        idle(1);
        check("pre_reset_count", count, 5);
        #2 rst = 0;
        #1 model_reset();
        check_all();
        check("async_pc_zero", update_pc, 0);
        @(posedge clk);
        #1 check_all();
        #2 rst = 1;
        idle(4);

        // statistics: 10 retires, 3 mispredicted
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_in(1, 32'h6000 + 32'(k * 4), 2'b10, 0, 0, 0, 0, 0); step();
            set_in(0, 0, 0, 1, m_tail == 0 ? DEPTH - 1 : m_tail - 1, k >= 3, 0, 0); step();
            idle(2);
        end
`ifdef BRQ_STATS_EN
        check("stats_updates_10", stat_updates, 10);
        check("stats_mispred_3", stat_mispred, 3);
`else
        check("stats_updates_off", stat_updates, 0);
        check("stats_mispred_off", stat_mispred, 0);
`endif

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit fv = ($urandom_range(0, 19) == 0);
            bit rv = ($urandom_range(0, 1) == 1);
            int rt = (mq.size() > 0 && $urandom_range(0, 4) != 0)
                     ? mq[$urandom_range(0, mq.size() - 1)].tag : int'($urandom_range(0, DEPTH - 1));
            int ft = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                     ? mq[$urandom_range(0, mq.size() - 1)].tag : int'($urandom_range(0, DEPTH - 1));
            set_in($urandom_range(0, 9) < 7, $urandom, 2'($urandom_range(0, 3)),
                   rv, rt, 1'($urandom_range(0, 1)), fv, ft);
            step();
        end
        idle(2);
        check("sb_leftover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/br_update_queue.md
# br_update_queue

In-order branch update queue that drives the commit-side update port of the TAGE predictor. The queue records each prediction at fetch (`pc`, 2-bit `pred`) and accepts out-of-order resolutions from execute by tag. It retires resolved entries strictly in allocation order as one-cycle update pulses (`update_valid/pc/taken/pred`), which also advance the predictor's GHR. It also handles pipeline flushes by squashing younger entries.

## Interface
- `DEPTH`, 8, number of entries; power of two, at least 2
- `IDX_W`, `$clog2(DEPTH)`, tag width
- `clk` in 1: single clock
- `rst` in 1: reset; asynchronous assert, active-low
- `alloc_valid` in 1: fetch requests an entry
- `alloc_pc` in 32: predicted branch PC
- `alloc_pred` in 2: predictor counter value at fetch
- `alloc_ready` out 1: entry available; `DEPTH - count != 0`
- `alloc_tag` out IDX_W: tag given to the allocating branch, equal to the tail pointer
- `resolve_valid` in 1: execute resolved a branch
- `resolve_tag` in IDX_W: tag of the resolved branch
- `resolve_taken` in 1: actual outcome
- `flush_valid` in 1: squash request
- `flush_tag` in IDX_W: oldest tag to discard; it and all younger entries are dropped
- `update_valid` out 1: registered one-cycle retire pulse
- `update_pc` out 32, `update_taken` out 1, `update_pred` out 2: retired entry contents
- `update_mispredict` out 1: `update_pred[1] != update_taken`
- `count` out IDX_W+1: occupied entries
- `stat_updates` out 32, `stat_mispred` out 32: statistics, see Configuration

## Operation
- Per-entry state: `valid`, `resolved`, `pc`, `pred`, `taken`. Head and tail pointers use IDX_W+1 bits, with the MSB as a wrap bit.
- **Alloc:** fires when `alloc_valid && alloc_ready && !flush_valid`. The entry at the tail is written with `valid=1, resolved=0`, and the tail advances modulo DEPTH.
- **Resolve:** when `resolve_valid` and the target entry is valid, the queue sets `resolved=1` and `taken=resolve_taken`. If the entry is already resolved, `taken` is overwritten. Resolves to an invalid entry, or to an entry squashed in the same cycle, are ignored.
- **Retire:** at each edge where the head entry is valid and `resolved` (the registered state), the queue does the following:
  - loads the `update_*` registers from the head entry and sets `update_valid=1`;
  - clears the entry's `valid` bit;
  - advances the head.
- Otherwise `update_valid=0`. At most one retire per cycle. Back-to-back retires are allowed.
- **Flush:** the tail is set to `flush_tag`, with the wrap bit chosen so that the distance `(flush_tag - head) mod DEPTH` is preserved. Entries from `flush_tag` up to the old tail are invalidated.
  - If `flush_tag` equals the head index, the queue empties and no retire occurs that cycle.
  - Otherwise, the head may retire in the same cycle.
  - A flush targeting a tag outside the occupied range is ignored.
- **Count:** `count_next = count + alloc - retire`. Under a flush, count is recomputed from the new pointers.
- **Priority in one cycle:** flush over alloc, flush over resolve to squashed entries; retire is independent of both.
- **Reset (rst low):** all entries invalid, head = tail = 0, `count=0`.
  - All update outputs are 0 and `update_pred=2'b00`.
  - Stats counters are 0.
  - `alloc_ready=1` and `alloc_tag=0` after reset.

## Timing
- `alloc_ready` and `alloc_tag` are combinational from registered state only. There are no input-to-output combinational paths.
- Resolve sampled at edge E → `resolved` visible after E → `update_valid` high for the cycle after E+1. Minimum resolve-to-update latency is 2 cycles.
- Alloc at edge E: earliest possible retire of that entry is in the cycle after E+2 (resolve presented in the cycle after E).
- **Full:** `alloc_ready=0` while `count==DEPTH`, even if a retire happens in the same cycle. Allocation resumes the cycle after the retire.
- **Empty:** no retire; the update outputs hold their last values with `update_valid=0`.
- Pointer wrap is seamless: tags reuse modulo DEPTH.
- Reset is asynchronous assert and synchronous-safe deassert. A mid-operation reset discards all entries immediately.

## Configuration
- `BRQ_STATS_EN` defined:
  - `stat_updates` increments on every retire.
  - `stat_mispred` increments on retires with `update_mispredict=1`.
  - Both counters saturate at `32'hFFFF_FFFF` and are reset to 0.
- `BRQ_STATS_EN` not defined: the counters are not built and both stat ports are tied to 0.

## Test plan
- **Reset then single branch:** alloc pc `0x100`, pred `2'b10` (tag 0), resolve tag 0 taken=0 → 2 cycles later one pulse with `update_pc=0x100`, `update_pred=2'b10`, `update_taken=0`, `update_mispredict=1`, `count` 1→0.
- **Out-of-order resolve:** alloc tags 0,1,2; resolve 2, then 1, then 0 → no update until tag 0 resolves. Then three consecutive pulses in order 0,1,2.
- **Full/wrap with DEPTH=8:** alloc 8 → `alloc_ready=0`, `count=8`. Resolve tag 0 → after the retire `alloc_ready=1` and the next `alloc_tag=0`. Repeat to 20 total allocs; all retire in order with no loss.
- **Flush:** entries 0–4 occupied; flush tag 2 with simultaneous resolve tag 3 → `count=2`, tag 3 is ignored, next `alloc_tag=2`. Flush at tag == head → `count=0`, no pulse.
- **Async reset mid-stream:** drop `rst` between clocks with 5 entries → outputs are 0 immediately, `count=0`, no `update_valid` after release.
- **With `BRQ_STATS_EN`:** 10 retires, 3 mispredicted → `stat_updates=10`, `stat_mispred=3`. Without the macro, both are 0.
